// File: rtl/membus_pkg.sv
// Shared types for the memory bus arbiter: FSM state encodings, grant codes and the
// wait-state limit, plus the data-first / alternate-on-conflict arbitration function.
package membus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    PC   = 2'd1,
    TX   = 2'd2
  } grant_t;

  localparam int unsigned WAIT_STATES_MAX = 15;

  // Data wins a tie unless data also won last time, so neither side can starve.
  function automatic grant_t arbitrate(logic fetch, logic data, grant_t last);
    grant_t win;
    win = NONE;
    if (fetch && data) begin
      win = (last == TX) ? PC : TX;
    end else if (data) begin
      win = TX;
    end else if (fetch) begin
      win = PC;
    end
    return win;
  endfunction

endpackage

// File: rtl/membus_arbiter_if.sv
// Handshake and memory-control bundle between the requesters and the bus arbiter.
interface membus_arbiter_if;
  logic FETCH_REQ;
  logic DATA_REQ;
  logic DATA_WE;
  logic ADDR_PC_ASSERT_bar;
  logic ADDR_TX_ASSERT_bar;
  logic MEM_OE_bar;
  logic MEM_WE_bar;
  logic FETCH_ACK;
  logic DATA_ACK;
  logic STALL;
  logic BUSY;

  modport master (
    output FETCH_REQ, DATA_REQ, DATA_WE,
    input  ADDR_PC_ASSERT_bar, ADDR_TX_ASSERT_bar, MEM_OE_bar, MEM_WE_bar,
    input  FETCH_ACK, DATA_ACK, STALL, BUSY
  );

  modport slave (
    input  FETCH_REQ, DATA_REQ, DATA_WE,
    output ADDR_PC_ASSERT_bar, ADDR_TX_ASSERT_bar, MEM_OE_bar, MEM_WE_bar,
    output FETCH_ACK, DATA_ACK, STALL, BUSY
  );
endinterface

// File: rtl/membus_waitcount.sv
// Loadable 4-bit wait-state down-counter; stops at zero and flags it.
module membus_waitcount (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 4'd0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != 4'd0)) begin
      count_q <= count_q - 4'd1;
    end
  end

  assign zero = (count_q == 4'd0);

endmodule

// File: rtl/membus_arbiter.sv
// Two-requester memory bus arbiter (fetch vs. data) with address setup and wait states.
// Optional saturating stall counter when MEMBUS_ARBITER_STALLCNT_EN is defined.
module membus_arbiter
  import membus_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input logic            CLK,
  input logic            RST,
  membus_arbiter_if.slave bus
`ifdef MEMBUS_ARBITER_STALLCNT_EN
  ,
  output logic [15:0]    STALL_COUNT
`endif
);

  localparam int unsigned WsClamp = (WAIT_STATES > WAIT_STATES_MAX) ? WAIT_STATES_MAX
                                                                   : WAIT_STATES;
  localparam logic [3:0] WsLoad = 4'(WsClamp);

  state_t state_q, state_d;
  grant_t grant_q, grant_d;
  grant_t last_q, last_d;
  logic   we_q, we_d;
  logic   wait_zero;
  logic   last_cycle;
  logic   stall;
  grant_t winner;

  membus_waitcount u_waitcount (
    .clk      (CLK),
    .rst      (RST),
    .load     (state_q == SETUP),
    .dec      (state_q == ACCESS),
    .load_val (WsLoad),
    .zero     (wait_zero)
  );

  assign last_cycle = (state_q == ACCESS) && wait_zero;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      grant_q <= NONE;
      last_q  <= PC;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    we_d    = we_q;
    winner  = NONE;
    unique case (state_q)
      IDLE:   winner = arbitrate(bus.FETCH_REQ, bus.DATA_REQ, last_q);
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        // The requester being acked still holds its REQ this cycle; ignore it.
        if (last_cycle) begin
          winner  = arbitrate(bus.FETCH_REQ && (grant_q != PC),
                              bus.DATA_REQ && (grant_q != TX), last_q);
          state_d = IDLE;
          grant_d = NONE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (winner != NONE) begin
      state_d = SETUP;
      grant_d = winner;
      last_d  = winner;
      we_d    = (winner == TX) ? bus.DATA_WE : 1'b0;
    end
  end

  assign stall = bus.FETCH_REQ && !bus.FETCH_ACK;

  always_comb begin
    bus.ADDR_PC_ASSERT_bar = !((state_q != IDLE) && (grant_q == PC));
    bus.ADDR_TX_ASSERT_bar = !((state_q != IDLE) && (grant_q == TX));
    bus.MEM_OE_bar         = !((state_q == ACCESS) && !we_q);
    // Write strobe drops one cycle early so data holds past WE rising, except with no waits.
    bus.MEM_WE_bar         = !((state_q == ACCESS) && we_q && (!wait_zero || (WsLoad == 4'd0)));
    bus.FETCH_ACK          = last_cycle && (grant_q == PC);
    bus.DATA_ACK           = last_cycle && (grant_q == TX);
    bus.STALL              = stall;
    bus.BUSY               = (state_q != IDLE);
  end

`ifdef MEMBUS_ARBITER_STALLCNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_q <= 16'd0;
    end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign STALL_COUNT = stall_cnt_q;
`endif

endmodule
